// File: rtl/seq_magnitude_subtractor.sv
// Multi-cycle |A - B - Cin| unit: one CHUNK-bit slice per clock, borrow chained, sign-fixed in a final cycle.
// Optional build macro SEQ_SUB_ABORT_EN adds an Abort input that cancels an operation in flight.
`timescale 1ns/1ps
module seq_magnitude_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
`ifdef SEQ_SUB_ABORT_EN
  input  logic             Abort,
`endif
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             Carry_in,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Positive_Diff,
  output logic             Is_negative,
  output logic             Mag_ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [WIDTH-1:0] pdiff_q, pdiff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             abort_w;
  logic [CHUNK:0]   chunk_sub;

  // MSB of the (CHUNK+1)-bit result is the borrow-out of the slice.
  function automatic logic [CHUNK:0] sub_chunk(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             bin);
    return {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] raw,
                                                 input logic             neg);
    return neg ? (~raw + WIDTH'(1'b1)) : raw;
  endfunction

`ifdef SEQ_SUB_ABORT_EN
  assign abort_w = Abort;
`else
  assign abort_w = 1'b0;
`endif

  // Operands are shifted right each SUB cycle so the active slice is always the low CHUNK bits.
  assign chunk_sub = sub_chunk(a_q[CHUNK-1:0], b_q[CHUNK-1:0], borrow_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    pdiff_d  = pdiff_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d  = SUB;
          a_d      = A_in;
          b_d      = B_in;
          borrow_d = Carry_in;
          cnt_d    = '0;
          diff_d   = '0;
        end
      end
      SUB: begin
        if (abort_w) begin
          state_d = IDLE;
        end else begin
          a_d      = a_q >> CHUNK;
          b_d      = b_q >> CHUNK;
          borrow_d = chunk_sub[CHUNK];
          // Fill the raw difference from the top so slice k lands at bit k*CHUNK after N shifts.
          diff_d   = (diff_q >> CHUNK) | (WIDTH'(chunk_sub[CHUNK-1:0]) << (WIDTH - CHUNK));
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!abort_w) begin
          neg_d   = borrow_q;
          pdiff_d = magnitude(diff_q, borrow_q);
          ovf_d   = borrow_q && (diff_q == '0);
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      pdiff_q  <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      pdiff_q  <= pdiff_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign Busy          = (state_q != IDLE);
  assign Done          = done_q;
  assign Positive_Diff = pdiff_q;
  assign Is_negative   = neg_q;
  assign Mag_ovf       = ovf_q;

endmodule

// File: tb/tb_seq_magnitude_subtractor.sv
// Scoreboard bench for seq_magnitude_subtractor: driver pushes expected results, monitor checks each Done.
`timescale 1ns/1ps
module tb_seq_magnitude_subtractor;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;
  localparam int LAT   = N + 2;  // cycles from the cycle Start is presented to the Done cycle

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic             Start = 1'b0;
  logic [WIDTH-1:0] A_in = '0;
  logic [WIDTH-1:0] B_in = '0;
  logic             Carry_in = 1'b0;
`ifdef SEQ_SUB_ABORT_EN
  logic             Abort = 1'b0;
`endif
  logic             Busy, Done, Is_negative, Mag_ovf;
  logic [WIDTH-1:0] Positive_Diff;

  seq_magnitude_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .Start(Start),
`ifdef SEQ_SUB_ABORT_EN
    .Abort(Abort),
`endif
    .A_in(A_in),
    .B_in(B_in),
    .Carry_in(Carry_in),
    .Busy(Busy),
    .Done(Done),
    .Positive_Diff(Positive_Diff),
    .Is_negative(Is_negative),
    .Mag_ovf(Mag_ovf)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [WIDTH-1:0] pd;
    logic             neg;
    logic             ovf;
    int               due;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             mon_e;
  int               cyc = 0;
  int               next_free = 0;
  int               checks = 0;
  int               errors = 0;
  bit               mon_en = 1'b0;
  logic [WIDTH-1:0] held_pd = '0;
  logic             held_neg = 1'b0;
  logic             held_ovf = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Reference: plain signed arithmetic on the full-precision difference.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input int due);
    exp_t   e;
    longint d;
    d     = longint'(a) - longint'(b) - longint'(cin);
    e.neg = (d < 0);
    if (d < 0) d = -d;
    e.ovf = (d == (longint'(1) << WIDTH));
    e.pd  = d[WIDTH-1:0];
    e.due = due;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  always @(negedge Clk) begin
    if (mon_en) begin
      if (Done) begin
        check("busy_in_done", 32'(Busy), 32'd0);
        if (sb_q.size() == 0) begin
          check("done_unexpected", 32'(Done), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("done_latency", cyc, mon_e.due);
          check("positive_diff", 32'(Positive_Diff), 32'(mon_e.pd));
          check("is_negative", 32'(Is_negative), 32'(mon_e.neg));
          check("mag_ovf", 32'(Mag_ovf), 32'(mon_e.ovf));
          held_pd  = mon_e.pd;
          held_neg = mon_e.neg;
          held_ovf = mon_e.ovf;
        end
      end else begin
        check("hold_pd", 32'(Positive_Diff), 32'(held_pd));
        check("hold_neg", 32'(Is_negative), 32'(held_neg));
        check("hold_ovf", 32'(Mag_ovf), 32'(held_ovf));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // A Start is accepted only when the reference says the unit is idle in this cycle.
  task automatic drive_cycle(input bit want, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic cin);
    Start    = want;
    A_in     = a;
    B_in     = b;
    Carry_in = cin;
    if (want && cyc >= next_free) begin
      sb_q.push_back(model(a, b, cin, cyc + LAT));
      next_free = cyc + LAT;
    end
    tick();
  endtask

  task automatic idle_until_free();
    while (cyc < next_free) drive_cycle(1'b0, rnd_op(), rnd_op(), 1'($urandom));
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    Start = 1'b0;
    while (sb_q.size() != 0 && budget < 4 * LAT) begin
      drive_cycle(1'b0, rnd_op(), rnd_op(), 1'($urandom));
      budget++;
    end
    check("pending_results", sb_q.size(), 0);
    sb_q.delete();
  endtask

  logic [WIDTH-1:0] dir_a [4] = '{16'h1234, 16'h0005, 16'h0000, 16'h0000};
  logic [WIDTH-1:0] dir_b [4] = '{16'h0034, 16'h0009, 16'h0000, 16'hFFFF};
  logic             dir_c [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int c0;
    repeat (3) tick();
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_pd", 32'(Positive_Diff), 32'd0);
    check("rst_neg", 32'(Is_negative), 32'd0);
    check("rst_ovf", 32'(Mag_ovf), 32'd0);

    // Release reset; the first Start is presented in the same cycle.
    Rst_n     = 1'b1;
    next_free = cyc;
    mon_en    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, dir_a[i], dir_b[i], dir_c[i]);
      idle_until_free();
    end

    // Random traffic, including Start pulses while busy that must be dropped.
    for (int i = 0; i < 300; i++)
      drive_cycle($urandom_range(0, 2) == 0, rnd_op(), rnd_op(), 1'($urandom));

    // Start held high with operands changing every cycle.
    for (int i = 0; i < 60; i++)
      drive_cycle(1'b1, rnd_op(), rnd_op(), 1'($urandom));
    drain();

    // Reset during SUB cycle 2 discards the operation.
    idle_until_free();
    c0 = cyc;
    drive_cycle(1'b1, 16'h8765, 16'h1234, 1'b0);
    while (cyc < c0 + 3) drive_cycle(1'b0, rnd_op(), rnd_op(), 1'b0);
    #2;
    Rst_n = 1'b0;
    sb_q.delete();
    held_pd  = '0;
    held_neg = 1'b0;
    held_ovf = 1'b0;
    #1;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_pd", 32'(Positive_Diff), 32'd0);
    check("midrst_neg", 32'(Is_negative), 32'd0);
    check("midrst_ovf", 32'(Mag_ovf), 32'd0);
    tick();
    Rst_n     = 1'b1;
    next_free = cyc;
    for (int i = 0; i < 2 * LAT; i++) drive_cycle(1'b0, rnd_op(), rnd_op(), 1'b0);
    drive_cycle(1'b1, 16'h0100, 16'h0200, 1'b1);
    idle_until_free();

`ifdef SEQ_SUB_ABORT_EN
    // Abort in SUB cycle 1 drops the operation; results keep their previous values.
    c0 = cyc;
    drive_cycle(1'b1, 16'h4444, 16'h1111, 1'b0);
    drive_cycle(1'b0, rnd_op(), rnd_op(), 1'b0);
    Abort = 1'b1;
    void'(sb_q.pop_back());
    next_free = c0 + 3;
    drive_cycle(1'b0, rnd_op(), rnd_op(), 1'b0);
    check("abort_busy", 32'(Busy), 32'd0);
    // Abort together with Start in IDLE: Start wins.
    drive_cycle(1'b1, 16'h0010, 16'h0003, 1'b1);
    Abort = 1'b0;
    idle_until_free();
`endif

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
